// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART transmit path.
//   - Frame controller state encoding (3-bit, legacy-compatible values).
//   - Line levels for the start and stop bits.
//   - Parity type select values for PAR_TYP.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational parity for one data word.
// Ports:
//   P_DATA  in  [DATA_WIDTH-1:0]  data word
//   PAR_TYP in  1                 PAR_EVEN / PAR_ODD
//   parity  out 1                 bit that makes the total count even/odd
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_TYP,
  output logic                  parity
);

  assign parity = (^P_DATA) ^ (PAR_TYP == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame controller. Builds start bit, serialized
// data (from the downstream serializer), optional parity and stop bit(s) on
// TX_OUT, and drives the serializer shift enable.
// Ports:
//   clk        in  1               bit clock, one bit period per cycle
//   RST        in  1               asynchronous reset, active-low
//   P_DATA     in  [DATA_WIDTH-1:0] parallel word, used for parity only
//   Data_Valid in  1               word-offer strobe
//   PAR_EN     in  1               1 inserts a parity bit
//   PAR_TYP    in  1               0 even, 1 odd
//   ser_data   in  1               current serializer data bit
//   ser_done   in  1               high while the last data bit is on ser_data
//   ser_en     out 1               serializer shift enable
//   busy       out 1               frame in progress (accept gate)
//   TX_OUT     out 1               serial line
// Build option: UART_TX_STOP2_EN defined -> two stop bits per frame.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       par_en_q;
  logic       par_bit_q;
  logic       par_calc;
  logic       accept;
  logic       stop_last;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .P_DATA (P_DATA),
    .PAR_TYP(PAR_TYP),
    .parity (par_calc)
  );

  assign accept = (state == IDLE) && Data_Valid && !busy;

`ifdef UART_TX_STOP2_EN
  // Low on the first stop cycle, high on the second.
  logic stop_cnt;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      stop_cnt <= 1'b0;
    end else if (state == STOP) begin
      stop_cnt <= ~stop_cnt;
    end else begin
      stop_cnt <= 1'b0;
    end
  end

  assign stop_last = stop_cnt;
`else
  assign stop_last = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (ser_done) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    if (stop_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The latched parity bit already folds in PAR_TYP, so the frame's parity
  // type is frozen through par_bit_q without a separate type flop.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      busy      <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        busy      <= 1'b1;
        par_en_q  <= PAR_EN;
        par_bit_q <= par_calc;
      end else if ((state == STOP) && stop_last) begin
        busy <= 1'b0;
      end
    end
  end

  always_comb begin
    TX_OUT = STOP_BIT;
    ser_en = 1'b0;
    case (state)
      START: begin
        TX_OUT = START_BIT;
        ser_en = 1'b1;
      end
      DATA: begin
        TX_OUT = ser_data;
        ser_en = !ser_done;
      end
      PARITY:  TX_OUT = par_bit_q;
      default: TX_OUT = STOP_BIT;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          ser_data;
  logic          ser_done;
  logic          ser_en;
  logic          busy;
  logic          TX_OUT;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .ser_data  (ser_data),
    .ser_done  (ser_done),
    .ser_en    (ser_en),
    .busy      (busy),
    .TX_OUT    (TX_OUT)
  );

  // Serializer model: loads on accept, the START-cycle enable arms it, then
  // each enabled DATA cycle shifts one bit out LSB first.
  logic [DW-1:0] sreg;
  int            scnt;
  logic          armed;

  always @(posedge clk or negedge RST) begin
    if (!RST) begin
      sreg  <= '0;
      scnt  <= 0;
      armed <= 1'b0;
    end else if (Data_Valid && !busy) begin
      sreg  <= P_DATA;
      scnt  <= 0;
      armed <= 1'b0;
    end else if (ser_done) begin
      armed <= 1'b0;
    end else if (ser_en) begin
      if (!armed) begin
        armed <= 1'b1;
      end else begin
        sreg <= sreg >> 1;
        scnt <= scnt + 1;
      end
    end
  end

  assign ser_data = sreg[0];
  assign ser_done = armed && (scnt == DW - 1);

  typedef struct {
    logic tx;
    logic en;
  } exp_t;

  exp_t exp_q[$];
  int   len_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-busy-cycle line value and ser_en for one frame.
  task automatic push_frame(input logic [DW-1:0] d, input logic pen, input logic pbit);
    exp_q.push_back('{tx: 1'b0, en: 1'b1});
    for (int i = 0; i < DW; i++) exp_q.push_back('{tx: d[i], en: (i != DW - 1)});
    if (pen) exp_q.push_back('{tx: pbit, en: 1'b0});
    for (int s = 0; s < NSTOP; s++) exp_q.push_back('{tx: 1'b1, en: 1'b0});
    len_q.push_back(1 + DW + (pen ? 1 : 0) + NSTOP);
  endtask

  // Single Data_Valid pulse; config inputs are scrambled right after accept.
  task automatic send(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                      input logic pbit);
    @(posedge clk);
    #1;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    push_frame(d, pen, pbit);
    @(posedge clk);
    #1;
    Data_Valid = 1'b0;
    P_DATA     = ~d;
    PAR_EN     = ~pen;
    PAR_TYP    = ~ptyp;
    check("accept_latency_busy", {31'd0, busy}, 32'd1);
    check("accept_latency_start", {31'd0, TX_OUT}, 32'd0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && busy; k++) begin
      @(posedge clk);
      #1;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: busy still 1 after 40 cycles, required 0");
    end
  endtask

  // Monitor: pops one expectation per busy cycle and checks the busy run length.
  exp_t e;
  int   run = 0;

  always @(negedge clk) begin
    if (!RST) begin
      run = 0;
    end else if (busy) begin
      run++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_busy: busy=1 with no frame expected at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("tx_bit", {31'd0, TX_OUT}, {31'd0, e.tx});
        check("ser_en", {31'd0, ser_en}, {31'd0, e.en});
      end
    end else begin
      if (run != 0) begin
        if (len_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL busy_len: run of %0d with no frame expected", run);
        end else begin
          check("busy_len", run, len_q.pop_front());
        end
        run = 0;
      end
      check("idle_tx", {31'd0, TX_OUT}, 32'd1);
      check("idle_ser_en", {31'd0, ser_en}, 32'd0);
    end
  end

  int   n;
  logic seen_low;
  logic done;

  initial begin
    #12;
    check("reset_tx", {31'd0, TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ser_en", {31'd0, ser_en}, 32'd0);
    @(posedge clk);
    #1;
    RST = 1'b1;

    // 0xA5, no parity: line 0,1,0,1,0,0,1,0,1 then stop.
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // 0x07 has three ones: even parity bit 1, odd parity bit 0.
    send(8'h07, 1'b1, 1'b0, 1'b1);
    wait_idle();
    send(8'h07, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // Data_Valid held high: frames repeat every frame length + 1 cycles.
    @(posedge clk);
    #1;
    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    push_frame(8'h55, 1'b0, 1'b0);
    push_frame(8'h55, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("b2b_first_busy", {31'd0, busy}, 32'd1);
    n = 0;
    seen_low = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) seen_low = 1'b1;
      else if (seen_low) done = 1'b1;
    end
    Data_Valid = 1'b0;
    check("b2b_period", n, 10 + NSTOP);
    wait_idle();

    // Offer of 0xFF during a 0x00 frame is dropped.
    send(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    P_DATA     = 8'hFF;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    Data_Valid = 1'b0;
    wait_idle();
    repeat (15) @(posedge clk);
    #1;
    check("ignored_offer_busy", {31'd0, busy}, 32'd0);
    check("ignored_offer_queue", exp_q.size(), 0);

    // Asynchronous reset during DATA bit 3, then a clean 0x3C frame.
    send(8'h96, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    RST = 1'b0;
    exp_q.delete();
    len_q.delete();
    #1;
    check("abort_tx", {31'd0, TX_OUT}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ser_en", {31'd0, ser_en}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b1;
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check("final_exp_queue", exp_q.size(), 0);
    check("final_len_queue", len_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
